// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the port-mapped UART transmitter.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Bit positions inside the status byte returned on IN
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  // Default port map, shared with the MCU wrapper
  localparam logic [7:0] DEF_DATA_ID   = 8'h83;
  localparam logic [7:0] DEF_STATUS_ID = 8'h84;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering outbound bytes ahead of the serializer.
// Read data is presented combinationally at the head entry, so a pop and a
// push on a full FIFO in the same cycle return the old head while the new
// byte lands in the slot being freed.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [3:0]       o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [3:0]       r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == 4'(DEPTH));
  assign o_empty   = (r_count == 4'd0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers and occupancy, wrapping at DEPTH (need not be a power of two)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 4'd0;
    end else begin
      if (w_push_ok) r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// Port-mapped 8N1 UART transmitter for the RAT MCU I/O bus.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | line high; pops the FIFO head into the shift register if any
//   START | start bit, line low for one bit period
//   DATA  | eight data bits, LSB first, shifted out of r_shift
//   STOP  | stop bit, line high; irq fires on exit if nothing is queued
module uart_tx_port import uart_tx_pkg::*; #(
  parameter int         CLK_HZ    = 100_000_000,
  parameter int         BAUD      = 9600,
  parameter logic [7:0] DATA_ID   = DEF_DATA_ID,
  parameter logic [7:0] STATUS_ID = DEF_STATUS_ID,
  parameter int         DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       io_strb,
  output logic [7:0] in_data,
  output logic       tx,
  output logic       irq
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int TW  = $clog2(DIV);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(DIV - 1);

  logic            r_strb;
  logic            w_wr;
  logic            w_wr_data;
  logic            w_wr_stat;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [3:0]      w_count;
  logic [7:0]      w_rdata;
  logic            r_ovf;
  logic [7:0]      w_status;

  tx_state_e       r_state;
  tx_state_e       w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_nxt;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic            r_irq;
  logic            w_irq_nxt;
  logic            w_tx;

  // A long strobe counts once: only its first cycle is a write
  assign w_wr      = io_strb && !r_strb;
  assign w_wr_data = w_wr && (port_id == DATA_ID);
  assign w_wr_stat = w_wr && (port_id == STATUS_ID);
  // A push on a full FIFO still succeeds when the IDLE pop frees a slot
  assign w_push    = w_wr_data && (!w_full || w_pop);

  tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_wdata (out_port),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Strobe history for edge detection and the sticky overflow flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_strb <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_strb <= io_strb;
      if (w_wr_stat)
        r_ovf <= 1'b0;
      else if (w_wr_data && w_full && !w_pop)
        r_ovf <= 1'b1;
    end
  end

  // Serializer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_irq     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_irq     <= w_irq_nxt;
    end
  end

  // Next-state, bit timer, shift and line level; each phase lasts DIV cycles
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_irq_nxt   = 1'b0;
    w_tx        = 1'b1;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_rdata;
          w_timer_nxt = TIMER_LOAD;
          w_state_nxt = START;
        end
      end
      START: begin
        w_tx = 1'b0;
        if (r_timer == '0) begin
          w_timer_nxt = TIMER_LOAD;
          w_bit_nxt   = 3'd0;
          w_state_nxt = DATA;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      DATA: begin
        w_tx = r_shift[0];
        if (r_timer == '0) begin
          w_timer_nxt = TIMER_LOAD;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7)
            w_state_nxt = STOP;
          else
            w_bit_nxt = r_bit_idx + 3'd1;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      STOP: begin
        if (r_timer == '0) begin
          w_state_nxt = IDLE;
          w_irq_nxt   = w_empty;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status byte assembled from live state; no extra latency on IN
  always_comb begin
    w_status                       = 8'h00;
    w_status[ST_FULL]              = w_full;
    w_status[ST_EMPTY]             = w_empty;
    w_status[ST_BUSY]              = (r_state != IDLE);
    w_status[ST_OVF]               = r_ovf;
    w_status[ST_CNT_LSB +: 4]      = w_count;
  end

  // Zero when not addressed so the wrapper can OR it into its input mux
  assign in_data = (port_id == STATUS_ID) ? w_status : 8'h00;
  assign tx      = w_tx;
  assign irq     = r_irq;

endmodule
